// File: rtl/elevator_car_if.sv
// Elevator car bus: request inputs from the button latch and car status outputs.
interface elevator_car_if;
    logic       tick;
    logic [7:0] req;
    logic [2:0] floor;
    logic       dir_up;
    logic       moving;
    logic       door_open;
    logic       arrive;

    // Controller side: drives the timebase and the request vector, observes the car.
    modport master (
        output tick, req,
        input  floor, dir_up, moving, door_open, arrive
    );

    // Car side: consumes tick/req, reports position and door state.
    modport slave (
        input  tick, req,
        output floor, dir_up, moving, door_open, arrive
    );
endinterface

// File: rtl/elevator_car.sv
// Single elevator car controller: IDLE / MOVE / DOOR state machine with
// tick-based travel and door timers. All outputs are registered.
module elevator_car #(
    parameter int FLOOR_TICKS = 4,
    parameter int DOOR_TICKS  = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    elevator_car_if.slave car
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MOVE = 2'd1;
    localparam logic [1:0] S_DOOR = 2'd2;

    localparam logic [7:0] FLOOR_LAST = 8'(FLOOR_TICKS - 1);
    localparam logic [7:0] DOOR_LAST  = 8'(DOOR_TICKS - 1);

    logic [1:0] state_q, state_d;
    logic [2:0] floor_q, floor_d;
    logic       dir_up_q, dir_up_d;
    logic [7:0] trav_q, trav_d;
    logic [7:0] door_q, door_d;
    logic       moving_q, door_open_q, arrive_q, arrive_d;

    logic       here, above, below;
    logic [2:0] step_floor;
    logic       at_end;

    // Any request strictly above floor f.
    function automatic logic any_above(input logic [7:0] r, input logic [2:0] f);
        logic [7:0] mask;
        mask = 8'hFE << f;
        return |(r & mask);
    endfunction

    // Any request strictly below floor f.
    function automatic logic any_below(input logic [7:0] r, input logic [2:0] f);
        logic [7:0] mask;
        mask = ~(8'hFF << f);
        return |(r & mask);
    endfunction

    assign here       = car.req[floor_q];
    assign above      = any_above(car.req, floor_q);
    assign below      = any_below(car.req, floor_q);
    assign step_floor = dir_up_q ? floor_q + 3'd1 : floor_q - 3'd1;
    // Defensive stop: the direction rules never put the car in MOVE facing the
    // end of the shaft, but if it ever happens the car halts instead of wrapping.
    assign at_end     = dir_up_q ? (floor_q == 3'd7) : (floor_q == 3'd0);

    // Next-state logic: IDLE decides immediately, MOVE/DOOR advance only on tick.
    always_comb begin
        state_d  = state_q;
        floor_d  = floor_q;
        dir_up_d = dir_up_q;
        trav_d   = trav_q;
        door_d   = door_q;
        arrive_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                trav_d = 8'd0;
                door_d = 8'd0;
                if (here) begin
                    state_d  = S_DOOR;
                    arrive_d = 1'b1;
                end else if (dir_up_q ? above : below) begin
                    state_d = S_MOVE;
                end else if (above) begin
                    state_d  = S_MOVE;
                    dir_up_d = 1'b1;
                end else if (below) begin
                    state_d  = S_MOVE;
                    dir_up_d = 1'b0;
                end
            end
            S_MOVE: begin
                if (car.tick) begin
                    if (trav_q == FLOOR_LAST) begin
                        trav_d = 8'd0;
                        if (at_end) begin
                            state_d = S_IDLE;
                        end else begin
                            // Decide against the floor we are arriving at.
                            floor_d = step_floor;
                            if (car.req[step_floor]) begin
                                state_d  = S_DOOR;
                                arrive_d = 1'b1;
                            end else if (dir_up_q ? any_above(car.req, step_floor)
                                                  : any_below(car.req, step_floor)) begin
                                state_d = S_MOVE;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end
                    end else begin
                        trav_d = trav_q + 8'd1;
                    end
                end
            end
            S_DOOR: begin
                // A fresh press at this floor keeps the door open from the start.
                if (here) begin
                    door_d = 8'd0;
                end else if (car.tick) begin
                    if (door_q == DOOR_LAST) begin
                        door_d  = 8'd0;
                        state_d = S_IDLE;
                    end else begin
                        door_d = door_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; async reset parks the car at floor 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            floor_q     <= 3'd0;
            dir_up_q    <= 1'b1;
            trav_q      <= 8'd0;
            door_q      <= 8'd0;
            moving_q    <= 1'b0;
            door_open_q <= 1'b0;
            arrive_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            floor_q     <= floor_d;
            dir_up_q    <= dir_up_d;
            trav_q      <= trav_d;
            door_q      <= door_d;
            moving_q    <= (state_d == S_MOVE);
            door_open_q <= (state_d == S_DOOR);
            arrive_q    <= arrive_d;
        end
    end

    assign car.floor     = floor_q;
    assign car.dir_up    = dir_up_q;
    assign car.moving    = moving_q;
    assign car.door_open = door_open_q;
    assign car.arrive    = arrive_q;

endmodule

// File: tb/tb_elevator_car.sv
// Bench for elevator_car: directed scenarios followed by random presses and
// ticks, every cycle compared against a countdown-based behavioural model.
module tb_elevator_car;

    localparam int FT = 4;
    localparam int DT = 6;

    localparam int M_IDLE = 0;
    localparam int M_MOVE = 1;
    localparam int M_DOOR = 2;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    elevator_car_if bus ();

    elevator_car #(.FLOOR_TICKS(FT), .DOOR_TICKS(DT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .car   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int dut_arrivals = 0;

    // Reference model: position, heading, and remaining ticks for the current leg.
    int m_state;
    int m_floor;
    int trav_left;
    int door_left;
    bit m_up;
    bit m_arrive;

    function automatic bit pending(input logic [7:0] r, input int lo, input int hi);
        bit hit;
        hit = 1'b0;
        for (int i = lo; i <= hi; i++)
            if (i >= 0 && i <= 7 && r[i] === 1'b1) hit = 1'b1;
        return hit;
    endfunction

    function automatic void model_reset();
        m_state   = M_IDLE;
        m_floor   = 0;
        m_up      = 1'b1;
        m_arrive  = 1'b0;
        trav_left = 0;
        door_left = 0;
    endfunction

    function automatic void open_door();
        m_state   = M_DOOR;
        door_left = DT;
        m_arrive  = 1'b1;
    endfunction

    function automatic void model_step(input bit tk, input logic [7:0] r);
        bit up_pend;
        bit dn_pend;
        m_arrive = 1'b0;
        if (m_state == M_IDLE) begin
            up_pend = pending(r, m_floor + 1, 7);
            dn_pend = pending(r, 0, m_floor - 1);
            if (r[m_floor] === 1'b1) begin
                open_door();
            end else if (up_pend || dn_pend) begin
                if (!(m_up ? up_pend : dn_pend)) m_up = up_pend;
                m_state   = M_MOVE;
                trav_left = FT;
            end
        end else if (m_state == M_MOVE) begin
            if (tk) begin
                trav_left--;
                if (trav_left == 0) begin
                    m_floor = m_up ? m_floor + 1 : m_floor - 1;
                    if (r[m_floor] === 1'b1)
                        open_door();
                    else if (m_up ? pending(r, m_floor + 1, 7) : pending(r, 0, m_floor - 1))
                        trav_left = FT;
                    else
                        m_state = M_IDLE;
                end
            end
        end else begin
            if (r[m_floor] === 1'b1) begin
                door_left = DT;
            end else if (tk) begin
                door_left--;
                if (door_left == 0) m_state = M_IDLE;
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic compare_outputs();
        check("floor",     32'(bus.floor),     32'(m_floor));
        check("dir_up",    32'(bus.dir_up),    32'(m_up));
        check("moving",    32'(bus.moving),    32'(m_state == M_MOVE));
        check("door_open", 32'(bus.door_open), 32'(m_state == M_DOOR));
        check("arrive",    32'(bus.arrive),    32'(m_arrive));
    endtask

    // One clk cycle: predict, clock, compare, then let the button latch clear
    // the request of a floor whose door is open.
    task automatic cycle(input bit tk);
        bus.tick = tk;
        model_step(tk, bus.req);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        compare_outputs();
        if (bus.arrive === 1'b1) dut_arrivals++;
        bus.tick = 1'b0;
        if (m_state == M_DOOR) bus.req[m_floor] = 1'b0;
    endtask

    task automatic run_until_idle(input int period, input int limit);
        int n;
        n = 0;
        while (!(m_state == M_IDLE && bus.req == 8'h00) && n < limit) begin
            cycle((cyc % period) == 0);
            n++;
        end
        checks++;
        assert (n < limit) else begin
            errors++;
            $error("FAIL timeout_idle observed=%0d expected_below=%0d", n, limit);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_outputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        bus.tick = 1'b0;
        bus.req  = 8'h00;
        rst_n    = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset state
        apply_reset();
        check("rst_floor", 32'(bus.floor), 32'd0);
        check("rst_dir",   32'(bus.dir_up), 32'd1);

        // Single request above: travel 0 -> 3, door, idle
        base = dut_arrivals;
        bus.req = 8'h08;
        cycle(1'b1);
        check("move_next_clk", 32'(bus.moving), 32'd1);
        run_until_idle(2, 400);
        check("req08_floor", 32'(bus.floor), 32'd3);
        check("req08_arrivals", 32'(dut_arrivals - base), 32'd1);

        // From floor 3 heading up: serve 7 first, then reverse to 0
        base = dut_arrivals;
        bus.req = 8'h81;
        run_until_idle(2, 1000);
        check("req81_floor", 32'(bus.floor), 32'd0);
        check("req81_dir", 32'(bus.dir_up), 32'd0);
        check("req81_arrivals", 32'(dut_arrivals - base), 32'd2);

        // Go to floor 2, then press floor 2 again while idle there
        bus.req = 8'h04;
        run_until_idle(1, 400);
        bus.req = 8'h04;
        cycle(1'b0);
        check("here_door", 32'(bus.door_open), 32'd1);
        check("here_arrive", 32'(bus.arrive), 32'd1);
        check("here_moving", 32'(bus.moving), 32'd0);
        cycle(1'b0);
        check("here_arrive_once", 32'(bus.arrive), 32'd0);
        run_until_idle(1, 400);

        // Door at floor 5 held open by a re-press after four door ticks
        base = dut_arrivals;
        bus.req = 8'h20;
        n = 0;
        while (m_state != M_DOOR && n < 200) begin
            cycle(1'b1);
            n++;
        end
        for (int i = 0; i < 4; i++) cycle(1'b1);
        bus.req[5] = 1'b1;
        cycle(1'b0);
        n = 0;
        while (bus.door_open === 1'b1 && n < 50) begin
            cycle(1'b1);
            n++;
        end
        check("repress_door_ticks", 32'(n), 32'(DT));
        check("repress_arrivals", 32'(dut_arrivals - base), 32'd1);
        check("repress_floor", 32'(bus.floor), 32'd5);

        // Request withdrawn mid-floor: step completes, car stops at 1
        apply_reset();
        base = dut_arrivals;
        bus.req = 8'h10;
        cycle(1'b0);
        cycle(1'b1);
        cycle(1'b1);
        bus.req = 8'h00;
        run_until_idle(1, 100);
        check("drop_floor", 32'(bus.floor), 32'd1);
        check("drop_arrivals", 32'(dut_arrivals - base), 32'd0);

        // Reset while moving past floor 6
        bus.req = 8'h80;
        n = 0;
        while (!(m_state == M_MOVE && m_floor == 6 && trav_left == FT - 2) && n < 400) begin
            cycle(1'b1);
            n++;
        end
        check("reach_floor6", 32'(bus.floor), 32'd6);
        bus.req = 8'h00;
        base = dut_arrivals;
        apply_reset();
        check("rst_mid_floor", 32'(bus.floor), 32'd0);
        for (int i = 0; i < 12; i++) cycle(1'b1);
        check("rst_mid_arrivals", 32'(dut_arrivals - base), 32'd0);

        // Random presses and tick spacing, with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) bus.req[$urandom_range(0, 7)] = 1'b1;
            if ($urandom_range(0, 599) == 0) begin
                bus.req = 8'h00;
                apply_reset();
            end
            cycle($urandom_range(0, 2) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/elevator_car.md
ELEVATOR_CAR -- requirements
Module: elevator_car

Interface
REQ-001 Parameter FLOOR_TICKS, default 4: tick pulses needed to travel one floor; legal range 1..255.
REQ-002 Parameter DOOR_TICKS, default 6: tick pulses the door stays open; legal range 1..255.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 tick  input  1  one-cycle timebase enable; all timing counts tick pulses, not clk cycles.
REQ-006 req  input  8  pending floor requests from the button latch, bit i = floor i; level-sensitive.
REQ-007 floor  output  3  current car floor, 0..7; fed back to the button latch so it clears the serviced request.
REQ-008 dir_up  output  1  current or last travel direction, 1 = up.
REQ-009 moving  output  1  high while in state MOVE.
REQ-010 door_open  output  1  high while in state DOOR.
REQ-011 arrive  output  1  one-clk pulse on every entry to DOOR.

Function
REQ-012 The block SHALL be a 3-state FSM: IDLE, MOVE, DOOR; all outputs registered.
REQ-013 Definitions: above = |req bits strictly above floor|; below = |req bits strictly below floor|; here = req[floor].
REQ-014 IDLE: here -> DOOR; else if dir_up && above, or !dir_up && below -> MOVE, direction unchanged; else if above -> MOVE, dir_up=1; else if below -> MOVE, dir_up=0; else remain IDLE.
REQ-015 IDLE decision SHALL take effect on the clk edge after the request is visible, independent of tick.
REQ-016 MOVE: an 8-bit travel counter SHALL increment on each tick; on the tick where it equals FLOOR_TICKS-1, floor SHALL step by +1 (dir_up) or -1 and the counter clear to 0.
REQ-017 On the same edge as the floor step, the FSM SHALL evaluate against the new floor: new req bit set -> DOOR; else requests remain ahead in dir_up -> stay MOVE; else -> IDLE.
REQ-018 Requests appearing or vanishing mid-floor SHALL NOT abort a floor step; evaluation occurs only at step completion.
REQ-019 floor SHALL never leave 0..7: in MOVE, a step toward 8 or toward -1 SHALL NOT occur because "ahead" is empty at floors 7/0; if ahead becomes empty mid-floor the step still completes and the car stops at the next floor.
REQ-020 DOOR: a door counter SHALL increment per tick; on the tick where it equals DOOR_TICKS-1 -> IDLE, counter cleared.
REQ-021 In DOOR, here asserting (new press at current floor) SHALL reload the door counter to 0; no new arrive pulse.
REQ-022 arrive SHALL be high for exactly the first clk cycle door_open is high, including entry from IDLE.
REQ-023 dir_up SHALL change only on IDLE->MOVE transitions.
REQ-024 tick coincident with a state transition edge SHALL be consumed by the old state only; the new state's counter starts at 0.
REQ-025 Counters SHALL be 8 bits and never wrap: comparison is equality against parameter-1.

Reset
REQ-026 While rst_n is low: state=IDLE, floor=0, dir_up=1, moving=0, door_open=0, arrive=0, both counters 0; asserted asynchronously, released synchronously to clk.
REQ-027 Reset asserted mid-MOVE or mid-DOOR SHALL abandon the operation; car reports floor 0 after release regardless of prior position.
REQ-028 The first clk edge after release SHALL evaluate IDLE rules against req.

Verification
REQ-029 Reset, req=8'h08, tick every 2 clk, defaults -> moving rises next clk, floor 1,2,3 at 4-tick intervals, arrive pulse with floor=3, door_open for 6 ticks, then IDLE.
REQ-030 Car at floor 3 going up, req=8'h81 -> continues up to 7, serves it, then MOVE down to 0 with dir_up=0.
REQ-031 IDLE at floor 2, req=8'h04 -> DOOR next clk, arrive=1 one cycle, moving never asserted.
REQ-032 DOOR at floor 5, req[5] re-pulsed at door tick 4 -> door stays open 6 further ticks, single arrive total.
REQ-033 Moving 0->4, req drops to 0 after 2 ticks -> car completes step to floor 1, goes IDLE, no arrive.
REQ-034 rst_n low mid-MOVE at floor 6 -> outputs immediately at reset values, floor=0, no arrive after release.
